// File: rtl/uart_rx_deserializer_if.sv
// Receive deserializer bundle: serial line and start pulse in,
// assembled word, strobe and error flags out.
interface uart_rx_deserializer_if #(
    parameter int DATA_BITS = 8
);
    logic                 rxbit;
    logic                 start_det;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output rxbit, start_det,
        input  data, valid, frame_err, parity_err, busy
    );

    modport slave (
        input  rxbit, start_det,
        output data, valid, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: times mid-bit samples after start_det,
// shifts LSB-first data, checks optional parity and the stop bit.
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIRST_MID  = 12,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input logic                  clk,
    input logic                  rst,
    uart_rx_deserializer_if.slave bus
);
    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    localparam logic [CW-1:0] FIRST_LD = CW'(FIRST_MID - 1);
    localparam logic [CW-1:0] BIT_LD   = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic          PAR_ON   = (PARITY_EN != 0);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 parbit;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 fe_q;
    logic                 pe_q;
    logic                 busy_q;
    logic                 at_mid;

    assign at_mid = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            parbit  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start_det) begin
                        cnt    <= FIRST_LD;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (at_mid) begin
                        shreg[idx] <= bus.rxbit;
                        cnt        <= BIT_LD;
                        if (idx == LAST_IDX)
                            state <= PAR_ON ? PARITY : STOP;
                        else
                            idx <= idx + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PARITY: begin
                    if (at_mid) begin
                        parbit <= bus.rxbit;
                        cnt    <= BIT_LD;
                        state  <= STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (at_mid) begin
                        valid_q <= 1'b1;
                        data_q  <= shreg;
                        fe_q    <= ~bus.rxbit;
                        // even parity: nonzero XOR is an error; odd flips it
                        pe_q    <= PAR_ON &&
                                   ((^shreg ^ parbit) != PAR_ODD);
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.frame_err  = fe_q;
    assign bus.parity_err = pe_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench: default-config and even-parity deserializers driven
// from absolute-cycle line tables, checked with immediate assertions.
module tb_uart_rx_deserializer;
    localparam int MAXC = 1600;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_rx_deserializer_if #(.DATA_BITS(8)) b0 ();
    uart_rx_deserializer_if #(.DATA_BITS(8)) b1 ();

    uart_rx_deserializer #(
        .DATA_BITS(8), .OVERSAMPLE(16), .FIRST_MID(12),
        .PARITY_EN(0), .PARITY_ODD(0)
    ) u0 (
        .clk(clk), .rst(rst), .bus(b0)
    );

    uart_rx_deserializer #(
        .DATA_BITS(8), .OVERSAMPLE(16), .FIRST_MID(12),
        .PARITY_EN(1), .PARITY_ODD(0)
    ) u1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    bit line0 [MAXC];
    bit line1 [MAXC];
    bit sd0   [MAXC];
    bit sd1   [MAXC];

    int cyc    = 0;
    int vcnt0  = 0;
    int vcnt1  = 0;
    int passed = 0;
    int total  = 0;

    // Line value at edge t+j; start_det pulse sampled at edge t.
    task automatic put(input int sel, input int t, input logic [8:0] d,
                       input int nb, input int pen,
                       input logic pb, input logic sb);
        int last;
        last = 12 + 16 * (nb + pen);
        for (int j = 1; j <= last; j++) begin
            int   s;
            logic v;
            s = (j + 12) / 16;
            if (s == 0)                        v = 1'b0;
            else if (s <= nb)                  v = d[s-1];
            else if (pen != 0 && s == nb + 1)  v = pb;
            else                               v = sb;
            if (sel == 0) line0[t+j] = v;
            else          line1[t+j] = v;
        end
        if (sel == 0) sd0[t] = 1'b1;
        else          sd1[t] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (b0.valid) vcnt0++;
        if (b1.valid) vcnt1++;
        b0.rxbit     = line0[cyc+1];
        b0.start_det = sd0[cyc+1];
        b1.rxbit     = line1[cyc+1];
        b1.start_det = sd1[cyc+1];
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            line0[i] = 1'b1;
            line1[i] = 1'b1;
        end
        put(0,   10, 9'h0A5, 8, 0, 1'b0, 1'b1);
        put(0,  200, 9'h0A5, 8, 0, 1'b0, 1'b0);
        put(0,  400, 9'h05A, 8, 0, 1'b0, 1'b1);
        sd0[450] = 1'b1;
        sd0[540] = 1'b1;
        put(0,  541, 9'h0C3, 8, 0, 1'b0, 1'b1);
        put(0,  800, 9'h077, 8, 0, 1'b0, 1'b1);
        put(0, 1000, 9'h03C, 8, 0, 1'b0, 1'b1);
        put(0, 1200, 9'h000, 8, 0, 1'b0, 1'b1);
        put(0, 1341, 9'h0FF, 8, 0, 1'b0, 1'b1);
        put(1,   10, 9'h003, 8, 1, 1'b0, 1'b1);
        put(1,  200, 9'h003, 8, 1, 1'b1, 1'b1);

        b0.rxbit = 1'b1; b0.start_det = 1'b0;
        b1.rxbit = 1'b1; b1.start_det = 1'b0;

        run_to(3);
        chk("rst_busy",  32'(b0.busy), 32'h0);
        chk("rst_valid", 32'(b0.valid), 32'h0);
        chk("rst_data",  32'(b0.data), 32'h0);
        chk("rst_fe",    32'(b0.frame_err), 32'h0);
        rst = 1'b0;

        run_to(9);
        chk("f1_busy_pre", 32'(b0.busy), 32'h0);
        run_to(10);
        chk("f1_busy_T", 32'(b0.busy), 32'h1);
        run_to(149);
        chk("f1_busy_139", 32'(b0.busy), 32'h1);
        chk("f1_valid_139", 32'(b0.valid), 32'h0);
        run_to(150);
        chk("f1_valid", 32'(b0.valid), 32'h1);
        chk("f1_data", 32'(b0.data), 32'hA5);
        chk("f1_fe", 32'(b0.frame_err), 32'h0);
        chk("f1_pe", 32'(b0.parity_err), 32'h0);
        chk("f1_busy_end", 32'(b0.busy), 32'h0);
        run_to(151);
        chk("f1_valid_off", 32'(b0.valid), 32'h0);
        chk("f1_data_hold", 32'(b0.data), 32'hA5);

        run_to(165);
        chk("p0_busy", 32'(b1.busy), 32'h1);
        chk("p0_valid_pre", 32'(b1.valid), 32'h0);
        run_to(166);
        chk("p0_valid", 32'(b1.valid), 32'h1);
        chk("p0_data", 32'(b1.data), 32'h03);
        chk("p0_pe", 32'(b1.parity_err), 32'h0);
        run_to(167);
        chk("p0_valid_off", 32'(b1.valid), 32'h0);

        run_to(340);
        chk("f2_valid", 32'(b0.valid), 32'h1);
        chk("f2_data", 32'(b0.data), 32'hA5);
        chk("f2_fe", 32'(b0.frame_err), 32'h1);
        run_to(341);
        chk("f2_idle", 32'(b0.busy), 32'h0);
        chk("f2_vcnt", 32'(vcnt0), 32'd2);

        run_to(356);
        chk("p1_valid", 32'(b1.valid), 32'h1);
        chk("p1_pe", 32'(b1.parity_err), 32'h1);
        chk("p1_fe", 32'(b1.frame_err), 32'h0);

        run_to(540);
        chk("f3_valid", 32'(b0.valid), 32'h1);
        chk("f3_data", 32'(b0.data), 32'h5A);
        run_to(541);
        chk("f3_restart", 32'(b0.busy), 32'h1);
        run_to(681);
        chk("f3b_valid", 32'(b0.valid), 32'h1);
        chk("f3b_data", 32'(b0.data), 32'hC3);
        run_to(690);
        chk("f3_vcnt", 32'(vcnt0), 32'd4);

        run_to(869);
        chk("f4_busy_pre", 32'(b0.busy), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        chk("f4_rst_busy", 32'(b0.busy), 32'h0);
        chk("f4_rst_data", 32'(b0.data), 32'h0);
        chk("f4_rst_valid", 32'(b0.valid), 32'h0);
        run_to(871);
        rst = 1'b0;
        run_to(1000);
        chk("f4_no_valid", 32'(vcnt0), 32'd4);
        chk("f4_busy_T", 32'(b0.busy), 32'h1);
        run_to(1140);
        chk("f4_valid", 32'(b0.valid), 32'h1);
        chk("f4_data", 32'(b0.data), 32'h3C);
        chk("f4_fe", 32'(b0.frame_err), 32'h0);

        run_to(1340);
        chk("f5a_valid", 32'(b0.valid), 32'h1);
        chk("f5a_data", 32'(b0.data), 32'h00);
        chk("f5a_fe", 32'(b0.frame_err), 32'h0);
        run_to(1481);
        chk("f5b_valid", 32'(b0.valid), 32'h1);
        chk("f5b_data", 32'(b0.data), 32'hFF);
        chk("f5b_fe", 32'(b0.frame_err), 32'h0);
        run_to(1485);
        chk("f5_vcnt", 32'(vcnt0), 32'd7);
        chk("p_vcnt", 32'(vcnt1), 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
